sys_bus_mem_model: RTL and testbench

- Behavioural target memory on the system-bus side of the AXI3 slave DUT.
- Consumes the DUT's sys_addr/sys_wdata/sys_sel/sys_wen/sys_ren request pulses.
- Returns sys_rdata/sys_err/sys_ack after a fixed, parameterised latency.
- Gives the UVM environment a deterministic, checkable endpoint, with transaction counters for scoreboard cross-checks.

---
 rtl/sys_bus_pkg.sv | 22 ++
 rtl/sys_bus_mem_array.sv | 33 +++
 rtl/sys_bus_mem_model.sv | 175 +++++++++++++++++
 tb/tb_sys_bus_mem_model.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus memory model.
package sys_bus_pkg;

    localparam int SYS_CNT_W = 16;
    // Bus widths carried by the request record; the model's bus widths follow these.
    localparam int SYS_AW    = 32;
    localparam int SYS_DW    = 64;
    localparam int SYS_SW    = SYS_DW / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef enum logic {OP_RD, OP_WR} op_t;

    typedef struct packed {
        logic [SYS_AW-1:0] addr;
        logic [SYS_DW-1:0] wdata;
        logic [SYS_SW-1:0] sel;
        op_t               op;
        logic              dual;   // wen and ren arrived together
    } req_t;

endpackage

// File: rtl/sys_bus_mem_array.sv
// Byte-enabled single-port word array: registered write, combinational read.
module sys_bus_mem_array
    import sys_bus_pkg::*;
#(
    parameter int DW    = SYS_DW,
    parameter int SW    = DW / 8,
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
)(
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [SW-1:0]    i_sel,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [DW-1:0]    i_wdata,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Update only the byte lanes whose select bit is set; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < SW; k++) begin
                if (i_sel[k]) begin
                    r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/sys_bus_mem_model.sv
// Behavioural target memory for the system-bus side of the AXI3 slave:
// accepts one request at a time, answers after ACK_LAT cycles, counts traffic.
module sys_bus_mem_model
    import sys_bus_pkg::*;
#(
    parameter int                AXI_DW    = SYS_DW,
    parameter int                AXI_AW    = SYS_AW,
    parameter int                AXI_SW    = AXI_DW / 8,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [AXI_AW-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int                ACK_LAT   = 2
)(
    input  logic                 axi_clk_i,
    input  logic                 axi_rstn_i,
    input  logic [AXI_AW-1:0]    sys_addr_i,
    input  logic [AXI_DW-1:0]    sys_wdata_i,
    input  logic [AXI_SW-1:0]    sys_sel_i,
    input  logic                 sys_wen_i,
    input  logic                 sys_ren_i,
    output logic [AXI_DW-1:0]    sys_rdata_o,
    output logic                 sys_err_o,
    output logic                 sys_ack_o,
    output logic [SYS_CNT_W-1:0] wr_cnt_o,
    output logic [SYS_CNT_W-1:0] rd_cnt_o,
    output logic [SYS_CNT_W-1:0] err_cnt_o,
    output logic [SYS_CNT_W-1:0] drop_cnt_o
);

    localparam int SW_LG = $clog2(AXI_SW);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    function automatic logic [SYS_CNT_W-1:0] sat_inc(input logic [SYS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    req_t                 r_req;
    logic [3:0]           r_lat;
    logic [SYS_CNT_W-1:0] r_wr_cnt;
    logic [SYS_CNT_W-1:0] r_rd_cnt;
    logic [SYS_CNT_W-1:0] r_err_cnt;
    logic [SYS_CNT_W-1:0] r_drop_cnt;

    logic                 w_req;
    logic [AXI_AW:0]      w_off;
    logic [AXI_AW:0]      w_off_sh;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_oor;
    logic                 w_err;
    logic                 w_mem_we;
    logic [AXI_DW-1:0]    w_mem_rdata;

    assign w_req = sys_wen_i | sys_ren_i;

    // The extra top bit holds the borrow, so addresses below BASE_ADDR land
    // in the high part of the shifted offset and read as out of range.
    assign w_off    = {1'b0, r_req.addr} - {1'b0, BASE_ADDR};
    assign w_off_sh = w_off >> SW_LG;
    assign w_idx    = w_off_sh[IDX_W-1:0];
    assign w_oor    = |w_off_sh[AXI_AW:IDX_W];
    assign w_err    = w_oor | r_req.dual;

    sys_bus_mem_array #(
        .DW    (AXI_DW),
        .SW    (AXI_SW),
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .i_clk   (axi_clk_i),
        .i_we    (w_mem_we),
        .i_sel   (r_req.sel),
        .i_idx   (w_idx),
        .i_wdata (r_req.wdata),
        .o_rdata (w_mem_rdata)
    );

    // State register.
    always_ff @(posedge axi_clk_i) begin
        if (!axi_rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and response outputs; responses exist only during RESP.
    always_comb begin
        w_state_nxt = r_state;
        sys_ack_o   = 1'b0;
        sys_err_o   = 1'b0;
        sys_rdata_o = '0;
        w_mem_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = (ACK_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_lat == 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                sys_ack_o   = 1'b1;
                sys_err_o   = w_err;
                w_mem_we    = (r_req.op == OP_WR) && !w_err;
                if ((r_req.op == OP_RD) && !w_err) begin
                    sys_rdata_o = w_mem_rdata;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture the accepted request; data is not reset because it is only used after a capture.
    always_ff @(posedge axi_clk_i) begin
        if ((r_state == IDLE) && w_req) begin
            r_req.addr  <= sys_addr_i;
            r_req.wdata <= sys_wdata_i;
            r_req.sel   <= sys_sel_i;
            r_req.op    <= sys_wen_i ? OP_WR : OP_RD;
            r_req.dual  <= sys_wen_i & sys_ren_i;
        end
    end

    // Latency countdown and saturating traffic counters.
    always_ff @(posedge axi_clk_i) begin
        if (!axi_rstn_i) begin
            r_lat      <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_lat <= 4'(ACK_LAT - 1);
                    end
                end
                WAIT: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - 4'd1;
                    end
                    if (w_req) begin
                        r_drop_cnt <= sat_inc(r_drop_cnt);
                    end
                end
                RESP: begin
                    if (w_req) begin
                        r_drop_cnt <= sat_inc(r_drop_cnt);
                    end
                    if (r_req.op == OP_WR) begin
                        r_wr_cnt <= sat_inc(r_wr_cnt);
                    end else begin
                        r_rd_cnt <= sat_inc(r_rd_cnt);
                    end
                    if (w_err) begin
                        r_err_cnt <= sat_inc(r_err_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_cnt_o   = r_wr_cnt;
    assign rd_cnt_o   = r_rd_cnt;
    assign err_cnt_o  = r_err_cnt;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_sys_bus_mem_model.sv
// Scoreboard bench for sys_bus_mem_model: ACK_LAT=2 main instance plus
// ACK_LAT=1 and ACK_LAT=15 instances for latency checks.
module tb_sys_bus_mem_model;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [63:0] K    = 64'h0123_4567_89AB_CDEF;

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk;
        logic [63:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr  [3];
    logic [63:0] wdata [3];
    logic [7:0]  sel   [3];
    logic        wen   [3];
    logic        ren   [3];
    logic [63:0] rdata [3];
    logic        err   [3];
    logic        ack   [3];
    logic [15:0] wrc   [3];
    logic [15:0] rdc   [3];
    logic [15:0] errc  [3];
    logic [15:0] dropc [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0, exp_drop = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sys_bus_mem_model #(.ACK_LAT(2)) u_dut (
        .axi_clk_i(clk), .axi_rstn_i(rstn),
        .sys_addr_i(addr[0]), .sys_wdata_i(wdata[0]), .sys_sel_i(sel[0]),
        .sys_wen_i(wen[0]), .sys_ren_i(ren[0]),
        .sys_rdata_o(rdata[0]), .sys_err_o(err[0]), .sys_ack_o(ack[0]),
        .wr_cnt_o(wrc[0]), .rd_cnt_o(rdc[0]), .err_cnt_o(errc[0]), .drop_cnt_o(dropc[0])
    );

    sys_bus_mem_model #(.ACK_LAT(1)) u_lat1 (
        .axi_clk_i(clk), .axi_rstn_i(rstn),
        .sys_addr_i(addr[1]), .sys_wdata_i(wdata[1]), .sys_sel_i(sel[1]),
        .sys_wen_i(wen[1]), .sys_ren_i(ren[1]),
        .sys_rdata_o(rdata[1]), .sys_err_o(err[1]), .sys_ack_o(ack[1]),
        .wr_cnt_o(wrc[1]), .rd_cnt_o(rdc[1]), .err_cnt_o(errc[1]), .drop_cnt_o(dropc[1])
    );

    sys_bus_mem_model #(.ACK_LAT(15)) u_lat15 (
        .axi_clk_i(clk), .axi_rstn_i(rstn),
        .sys_addr_i(addr[2]), .sys_wdata_i(wdata[2]), .sys_sel_i(sel[2]),
        .sys_wen_i(wen[2]), .sys_ren_i(ren[2]),
        .sys_rdata_o(rdata[2]), .sys_err_o(err[2]), .sys_ack_o(ack[2]),
        .wr_cnt_o(wrc[2]), .rd_cnt_o(rdc[2]), .err_cnt_o(errc[2]), .drop_cnt_o(dropc[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int w);
        return (w == 0) ? 2 : ((w == 1) ? 1 : 15);
    endfunction

    task automatic push(input int w, input exp_t e);
        case (w)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic take(input int w, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{cyc: 0, err: 1'b0, chk: 1'b0, rdata: 64'd0};
        case (w)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Monitor: every ack pops one expected response and checks timing and payload.
    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) begin
            if (ack[w] === 1'b1) begin
                bit   ok;
                exp_t e;
                take(w, ok, e);
                if (!ok) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack[%0d]: got ack at cycle %0d, expected none", w, cyc);
                end else begin
                    check($sformatf("ack_cycle[%0d]", w), 64'(cyc), 64'(e.cyc));
                    check($sformatf("err[%0d]", w), {63'd0, err[w]}, {63'd0, e.err});
                    if (e.chk) check($sformatf("rdata[%0d]", w), rdata[w], e.rdata);
                end
            end
        end
    end

    // Caller is positioned at a negedge; the pulse lasts exactly one cycle.
    task automatic issue(input int w, input logic we, input logic re, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] s, input logic xerr,
                         input logic [63:0] xrd, input bit acked);
        exp_t e;
        wen[w]   = we;
        ren[w]   = re;
        addr[w]  = a;
        wdata[w] = d;
        sel[w]   = s;
        if (acked) begin
            e.cyc   = cyc + lat_of(w);
            e.err   = xerr;
            e.chk   = re & ~we;
            e.rdata = xrd;
            push(w, e);
            if (w == 0) begin
                if (we) exp_wr++; else exp_rd++;
                if (xerr) exp_err++;
            end
        end
        @(negedge clk);
        wen[w] = 1'b0;
        ren[w] = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got %0d pending responses, expected 0",
                     q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cnts(input int w, input int xwr, input int xrd, input int xer, input int xdr);
        check($sformatf("wr_cnt[%0d]", w),   64'(wrc[w]),   64'(xwr));
        check($sformatf("rd_cnt[%0d]", w),   64'(rdc[w]),   64'(xrd));
        check($sformatf("err_cnt[%0d]", w),  64'(errc[w]),  64'(xer));
        check($sformatf("drop_cnt[%0d]", w), 64'(dropc[w]), 64'(xdr));
    endtask

    task automatic check_main();
        check_cnts(0, exp_wr, exp_rd, exp_err, exp_drop);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t, expected earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        for (int w = 0; w < 3; w++) begin
            addr[w] = '0; wdata[w] = '0; sel[w] = '0; wen[w] = 1'b0; ren[w] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ack",   {63'd0, ack[0]}, 64'd0);
        check("rst_err",   {63'd0, err[0]}, 64'd0);
        check("rst_rdata", rdata[0], 64'd0);
        for (int w = 0; w < 3; w++) check_cnts(w, 0, 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Write then read
        issue(0, 1, 0, BASE, K, 8'hFF, 0, 64'd0, 1); drain();
        issue(0, 1, 0, 32'h4000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0, 1); drain();
        check_main();
        issue(0, 0, 1, 32'h4000_0008, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 1); drain();
        check_main();

        // Byte lanes and misaligned address
        issue(0, 1, 0, 32'h4000_0010, 64'd0, 8'hFF, 0, 64'd0, 1); drain();
        issue(0, 1, 0, 32'h4000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 64'd0, 1); drain();
        issue(0, 0, 1, 32'h4000_0010, 64'd0, 8'h00, 0, 64'h0000_0000_AAAA_AAAA, 1); drain();
        issue(0, 0, 1, 32'h4000_0013, 64'd0, 8'hFF, 0, 64'h0000_0000_AAAA_AAAA, 1); drain();

        // sel=0 write is a no-op that still acks cleanly
        issue(0, 1, 0, 32'h4000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'd0, 1); drain();
        issue(0, 0, 1, 32'h4000_0008, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 1); drain();

        // Last in-range word
        issue(0, 1, 0, 32'h4000_1FF8, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 64'd0, 1); drain();
        issue(0, 0, 1, 32'h4000_1FF8, 64'd0, 8'h00, 0, 64'hCAFE_F00D_1234_5678, 1); drain();
        check_main();

        // Out of range below and above the window
        issue(0, 0, 1, 32'h3FFF_FFF8, 64'd0, 8'h00, 1, 64'd0, 1); drain();
        issue(0, 1, 0, 32'h4000_2000, 64'h5555_5555_5555_5555, 8'hFF, 1, 64'd0, 1); drain();
        issue(0, 0, 1, BASE, 64'd0, 8'h00, 0, K, 1);
        issue(0, 0, 1, 32'h4000_1FF8, 64'd0, 8'h00, 1'b0, 64'hCAFE_F00D_1234_5678, 0);
        drain();
        issue(0, 0, 1, 32'h4000_1FF8, 64'd0, 8'h00, 0, 64'hCAFE_F00D_1234_5678, 1); drain();
        exp_drop++;
        check_main();

        // Dual wen+ren: errored write, memory untouched
        issue(0, 1, 1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 64'd0, 1); drain();
        issue(0, 0, 1, BASE, 64'd0, 8'h00, 0, K, 1); drain();
        check_main();

        // Busy drop, then back-to-back acceptance right after RESP
        issue(0, 0, 1, 32'h4000_0008, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 1);
        issue(0, 1, 0, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'd0, 0);
        exp_drop++;
        @(negedge clk);
        issue(0, 0, 1, 32'h4000_0010, 64'd0, 8'h00, 0, 64'h0000_0000_AAAA_AAAA, 1);
        drain();
        check_main();
        issue(0, 0, 1, BASE, 64'd0, 8'h00, 0, K, 1); drain();

        // ACK_LAT=1 instance
        issue(1, 1, 0, 32'h4000_0008, 64'hA1A2_A3A4_A5A6_A7A8, 8'hFF, 0, 64'd0, 1); drain();
        issue(1, 0, 1, 32'h4000_0008, 64'd0, 8'h00, 0, 64'hA1A2_A3A4_A5A6_A7A8, 1); drain();
        issue(1, 1, 1, 32'h4000_0008, 64'd0, 8'hFF, 1, 64'd0, 1); drain();
        issue(1, 0, 1, 32'h4000_0008, 64'd0, 8'h00, 0, 64'hA1A2_A3A4_A5A6_A7A8, 1); drain();
        check_cnts(1, 2, 2, 1, 0);

        // ACK_LAT=15 instance
        issue(2, 1, 0, 32'h4000_0018, 64'hB1B2_B3B4_B5B6_B7B8, 8'hFF, 0, 64'd0, 1); drain();
        issue(2, 0, 1, 32'h4000_0018, 64'd0, 8'h00, 0, 64'hB1B2_B3B4_B5B6_B7B8, 1); drain();
        check_cnts(2, 1, 1, 0, 0);

        // Reset mid-operation: pending write abandoned, no ack
        issue(0, 1, 0, BASE, 64'h0000_0000_0000_DEAD, 8'hFF, 0, 64'd0, 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_wr = 0; exp_rd = 0; exp_err = 0; exp_drop = 0;
        check_main();
        issue(0, 0, 1, BASE, 64'd0, 8'h00, 0, K, 1); drain();
        check_main();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
